ysyx_22040210_bpu_fixq: RTL and testbench

In-flight branch-prediction tracking queue between the fetch-side branch predictor and the resolve/commit stage. Records each prediction issued at IF (PC, history, counter, direction, target), pops it in order when the branch resolves, compares prediction against outcome, and drives the predictor's fix/update bus plus a mispredict redirect. It is the update-side counterpart of the BPU: the BPU produces predictions and consumes fixes; this block consumes predictions and produces fixes.

---
 rtl/ysyx_22040210_bpu_fixq.sv | 164 ++++++++++++++++
 tb/tb_ysyx_22040210_bpu_fixq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040210_bpu_fixq.sv
// ysyx_22040210_bpu_fixq
// In-flight branch prediction tracking queue. Each prediction issued at IF is
// recorded in order. When the oldest branch resolves, its record is popped,
// compared against the real outcome, and the predictor fix bus, the BTB update
// and a mispredict redirect are driven, all registered.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             pipeline flush, empties the queue
//   enq_*             prediction record from IF (valid/ready handshake)
//   res_*             resolve of the oldest branch (valid/ready handshake)
//   bpu_fix*_o        PHT/BHR fix bus (registered, fixwe is a pulse)
//   btb_fix*_o        BTB update (registered, fixwe is a pulse)
//   prmiss_o          mispredict pulse, redirect_pc_o the correct fetch PC
//   count_o           occupied entries (combinational from pointers)
module ysyx_22040210_bpu_fixq #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BHR_W = 8,
  parameter int unsigned AW    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [AW-1:0]            enq_pc_i,
  input  logic [BHR_W-1:0]         enq_bhr_i,
  input  logic [1:0]               enq_pht_i,
  input  logic                     enq_taken_i,
  input  logic [AW-1:0]            enq_target_i,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic                     res_isbr_i,
  input  logic                     res_taken_i,
  input  logic [AW-1:0]            res_target_i,
  input  logic [2:0]               res_jumpop_i,
  output logic                     bpu_fixwe_o,
  output logic [1:0]               bpu_fixpht_o,
  output logic [BHR_W-1:0]         bpu_fixbhr_o,
  output logic [AW-1:0]            bpu_fixpc_o,
  output logic                     btb_fixwe_o,
  output logic [AW-1:0]            bpu_fixjumpaddr_o,
  output logic [2:0]               btb_fixjumpop_o,
  output logic                     prmiss_o,
  output logic [AW-1:0]            redirect_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = PW - 1;

  // Entry storage
  logic [AW-1:0]    pc_q     [DEPTH];
  logic [BHR_W-1:0] bhr_q    [DEPTH];
  logic [1:0]       pht_q    [DEPTH];
  logic             taken_q  [DEPTH];
  logic [AW-1:0]    target_q [DEPTH];

  // Pointers carry a wrap bit above the index
  logic [PW-1:0] rptr, wptr;
  logic          full, empty;
  logic          push, pop, clear;

  // Head entry evaluation
  logic [AW-1:0]    head_pc;
  logic [BHR_W-1:0] head_bhr;
  logic [1:0]       head_pht;
  logic             head_taken;
  logic [AW-1:0]    head_target;
  logic             dirmiss, tgtmiss, miss;
  logic [1:0]       new_pht;
  logic [BHR_W-1:0] new_bhr;
  logic             btb_we;
  logic [AW-1:0]    redirect_pc;

  assign full  = (rptr[PW-1] != wptr[PW-1]) && (rptr[IW-1:0] == wptr[IW-1:0]);
  assign empty = (rptr == wptr);

  assign enq_ready_o = !full;
  assign res_ready_o = !empty;
  assign count_o     = wptr - rptr;

  assign push  = enq_valid_i && !full;
  assign pop   = res_valid_i && !empty;
  // A mispredict makes every younger entry wrong-path, same as a flush
  assign clear = flush || (pop && miss);

  // Compare the oldest prediction against the resolved outcome
  always_comb begin
    head_pc     = pc_q[rptr[IW-1:0]];
    head_bhr    = bhr_q[rptr[IW-1:0]];
    head_pht    = pht_q[rptr[IW-1:0]];
    head_taken  = taken_q[rptr[IW-1:0]];
    head_target = target_q[rptr[IW-1:0]];

    dirmiss = (res_taken_i != head_taken);
    tgtmiss = res_taken_i && head_taken && (res_target_i != head_target);
    miss    = dirmiss || tgtmiss;

    new_pht = head_pht;
    if (res_taken_i) begin
      if (head_pht != 2'd3) new_pht = head_pht + 2'd1;
    end else begin
      if (head_pht != 2'd0) new_pht = head_pht - 2'd1;
    end

    new_bhr     = {head_bhr[BHR_W-2:0], res_taken_i};
    btb_we      = res_taken_i && (!head_taken || tgtmiss);
    redirect_pc = res_taken_i ? res_target_i : head_pc + AW'(4);
  end

  // Record storage, written only when the record survives this edge
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) begin
      pc_q[wptr[IW-1:0]]     <= enq_pc_i;
      bhr_q[wptr[IW-1:0]]    <= enq_bhr_i;
      pht_q[wptr[IW-1:0]]    <= enq_pht_i;
      taken_q[wptr[IW-1:0]]  <= enq_taken_i;
      target_q[wptr[IW-1:0]] <= enq_target_i;
    end
  end

  // Pointers
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Registered fix / redirect outputs; strobes pulse, data holds
  always_ff @(posedge clk) begin
    if (rst) begin
      bpu_fixwe_o       <= 1'b0;
      bpu_fixpht_o      <= '0;
      bpu_fixbhr_o      <= '0;
      bpu_fixpc_o       <= '0;
      btb_fixwe_o       <= 1'b0;
      bpu_fixjumpaddr_o <= '0;
      btb_fixjumpop_o   <= '0;
      prmiss_o          <= 1'b0;
      redirect_pc_o     <= '0;
    end else begin
      bpu_fixwe_o <= 1'b0;
      btb_fixwe_o <= 1'b0;
      prmiss_o    <= 1'b0;
      if (pop) begin
        bpu_fixwe_o       <= res_isbr_i;
        bpu_fixpht_o      <= new_pht;
        bpu_fixbhr_o      <= new_bhr;
        bpu_fixpc_o       <= head_pc;
        btb_fixwe_o       <= btb_we;
        bpu_fixjumpaddr_o <= res_target_i;
        btb_fixjumpop_o   <= res_jumpop_i;
        prmiss_o          <= miss;
        redirect_pc_o     <= redirect_pc;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040210_bpu_fixq.sv
// Testbench for ysyx_22040210_bpu_fixq: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_ysyx_22040210_bpu_fixq;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned BHR_W = 8;
  localparam int unsigned AW    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          enq_valid_i;
  logic          enq_ready_o;
  logic [63:0]   enq_pc_i;
  logic [7:0]    enq_bhr_i;
  logic [1:0]    enq_pht_i;
  logic          enq_taken_i;
  logic [63:0]   enq_target_i;
  logic          res_valid_i;
  logic          res_ready_o;
  logic          res_isbr_i;
  logic          res_taken_i;
  logic [63:0]   res_target_i;
  logic [2:0]    res_jumpop_i;
  logic          bpu_fixwe_o;
  logic [1:0]    bpu_fixpht_o;
  logic [7:0]    bpu_fixbhr_o;
  logic [63:0]   bpu_fixpc_o;
  logic          btb_fixwe_o;
  logic [63:0]   bpu_fixjumpaddr_o;
  logic [2:0]    btb_fixjumpop_o;
  logic          prmiss_o;
  logic [63:0]   redirect_pc_o;
  logic [3:0]    count_o;

  ysyx_22040210_bpu_fixq #(.DEPTH(DEPTH), .BHR_W(BHR_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_pc_i(enq_pc_i), .enq_bhr_i(enq_bhr_i), .enq_pht_i(enq_pht_i),
    .enq_taken_i(enq_taken_i), .enq_target_i(enq_target_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_isbr_i(res_isbr_i), .res_taken_i(res_taken_i),
    .res_target_i(res_target_i), .res_jumpop_i(res_jumpop_i),
    .bpu_fixwe_o(bpu_fixwe_o), .bpu_fixpht_o(bpu_fixpht_o),
    .bpu_fixbhr_o(bpu_fixbhr_o), .bpu_fixpc_o(bpu_fixpc_o),
    .btb_fixwe_o(btb_fixwe_o), .bpu_fixjumpaddr_o(bpu_fixjumpaddr_o),
    .btb_fixjumpop_o(btb_fixjumpop_o), .prmiss_o(prmiss_o),
    .redirect_pc_o(redirect_pc_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an in-order list of outstanding predictions
  typedef struct {
    logic [63:0] pc;
    logic [7:0]  bhr;
    logic [1:0]  pht;
    logic        taken;
    logic [63:0] target;
  } rec_t;

  rec_t        q[$];
  logic        m_fixwe, m_btbwe, m_prmiss;
  logic [1:0]  m_fixpht;
  logic [7:0]  m_fixbhr;
  logic [63:0] m_fixpc, m_jaddr, m_redir;
  logic [2:0]  m_jop;

  task automatic model_clear_outs();
    m_fixwe = 1'b0; m_btbwe = 1'b0; m_prmiss = 1'b0;
    m_fixpht = '0; m_fixbhr = '0; m_fixpc = '0;
    m_jaddr = '0; m_redir = '0; m_jop = '0;
  endtask

  // One clock: check ready/count, advance the model, check registered outputs
  task automatic tick();
    rec_t e;
    rec_t n;
    bit   pop, push, miss, wrong_tgt;
    int   p;
    check("count", 64'(count_o), 64'(q.size()));
    check("enq_ready", 64'(enq_ready_o), 64'(q.size() < DEPTH));
    check("res_ready", 64'(res_ready_o), 64'(q.size() > 0));
    if (rst) begin
      q.delete();
      model_clear_outs();
    end else begin
      pop  = res_valid_i && (q.size() > 0);
      push = enq_valid_i && (q.size() < DEPTH);
      miss = 1'b0;
      m_fixwe = 1'b0; m_btbwe = 1'b0; m_prmiss = 1'b0;
      if (pop) begin
        e = q[0];
        wrong_tgt = res_taken_i && e.taken && (res_target_i != e.target);
        miss = (res_taken_i != e.taken) || wrong_tgt;
        p = int'(e.pht) + (res_taken_i ? 1 : -1);
        if (p > 3) p = 3;
        if (p < 0) p = 0;
        m_fixwe  = res_isbr_i;
        m_fixpht = 2'(p);
        m_fixbhr = {e.bhr[6:0], res_taken_i};
        m_fixpc  = e.pc;
        m_btbwe  = res_taken_i && (!e.taken || wrong_tgt);
        m_jaddr  = res_target_i;
        m_jop    = res_jumpop_i;
        m_prmiss = miss;
        m_redir  = res_taken_i ? res_target_i : e.pc + 64'd4;
      end
      if (flush || miss) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          n.pc = enq_pc_i; n.bhr = enq_bhr_i; n.pht = enq_pht_i;
          n.taken = enq_taken_i; n.target = enq_target_i;
          q.push_back(n);
        end
      end
    end
    @(posedge clk);
    #1;
    check("fixwe", 64'(bpu_fixwe_o), 64'(m_fixwe));
    check("fixpht", 64'(bpu_fixpht_o), 64'(m_fixpht));
    check("fixbhr", 64'(bpu_fixbhr_o), 64'(m_fixbhr));
    check("fixpc", bpu_fixpc_o, m_fixpc);
    check("btbwe", 64'(btb_fixwe_o), 64'(m_btbwe));
    check("jaddr", bpu_fixjumpaddr_o, m_jaddr);
    check("jop", 64'(btb_fixjumpop_o), 64'(m_jop));
    check("prmiss", 64'(prmiss_o), 64'(m_prmiss));
    check("redirect", redirect_pc_o, m_redir);
  endtask

  task automatic set_idle();
    enq_valid_i = 1'b0; res_valid_i = 1'b0; flush = 1'b0;
  endtask

  task automatic set_enq(input logic [63:0] pc, input logic [7:0] bhr, input logic [1:0] pht,
                         input logic taken, input logic [63:0] tgt);
    enq_valid_i = 1'b1; enq_pc_i = pc; enq_bhr_i = bhr;
    enq_pht_i = pht; enq_taken_i = taken; enq_target_i = tgt;
  endtask

  task automatic set_res(input logic isbr, input logic taken, input logic [63:0] tgt, input logic [2:0] op);
    res_valid_i = 1'b1; res_isbr_i = isbr; res_taken_i = taken;
    res_target_i = tgt; res_jumpop_i = op;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    enq_pc_i = '0; enq_bhr_i = '0; enq_pht_i = '0; enq_taken_i = 1'b0; enq_target_i = '0;
    res_isbr_i = 1'b0; res_taken_i = 1'b0; res_target_i = '0; res_jumpop_i = '0;
    model_clear_outs();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    check("rst_res_ready", 64'(res_ready_o), 64'd0);
    check("rst_strobes", 64'({bpu_fixwe_o, btb_fixwe_o, prmiss_o}), 64'd0);
    tick();
    rst = 1'b0;

    // Fill to capacity, one extra offer dropped, drain in order; twice for wrap
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 9; i++) begin
        set_enq(64'h100 + 64'(4 * i) + 64'(pass * 'h1000), 8'(i), 2'd1, 1'b0, 64'h0);
        tick();
      end
      set_idle();
      check("full_count", 64'(count_o), 64'd8);
      check("full_enq_ready", 64'(enq_ready_o), 64'd0);
      for (int i = 0; i < 8; i++) begin
        set_res(1'b1, 1'b0, 64'h0, 3'd0);
        tick();
        check("order_pc", bpu_fixpc_o, 64'h100 + 64'(4 * i) + 64'(pass * 'h1000));
      end
      set_idle();
      tick();
    end

    // Correct taken, pht 2 -> 3
    set_enq(64'h40, 8'h00, 2'd2, 1'b1, 64'h200); tick(); set_idle();
    set_res(1'b1, 1'b1, 64'h200, 3'd1); tick(); set_idle();
    check("hit_fixwe", 64'(bpu_fixwe_o), 64'd1);
    check("hit_pht", 64'(bpu_fixpht_o), 64'd3);
    check("hit_btbwe", 64'(btb_fixwe_o), 64'd0);
    check("hit_prmiss", 64'(prmiss_o), 64'd0);
    // pht 3 taken saturates
    set_enq(64'h44, 8'h00, 2'd3, 1'b1, 64'h200); tick(); set_idle();
    set_res(1'b1, 1'b1, 64'h200, 3'd1); tick(); set_idle();
    check("sat_hi_pht", 64'(bpu_fixpht_o), 64'd3);
    // pht 0 not-taken saturates
    set_enq(64'h48, 8'h00, 2'd0, 1'b0, 64'h0); tick(); set_idle();
    set_res(1'b1, 1'b0, 64'h0, 3'd0); tick(); set_idle();
    check("sat_lo_pht", 64'(bpu_fixpht_o), 64'd0);

    // Direction miss with younger entries queued
    set_enq(64'h8000_0010, 8'h5A, 2'd1, 1'b0, 64'h0); tick();
    set_enq(64'h8000_0014, 8'h00, 2'd1, 1'b0, 64'h0); tick();
    set_enq(64'h8000_0018, 8'h00, 2'd1, 1'b0, 64'h0); tick(); set_idle();
    set_res(1'b1, 1'b1, 64'h8000_0100, 3'd2); tick(); set_idle();
    check("dmiss_prmiss", 64'(prmiss_o), 64'd1);
    check("dmiss_redirect", redirect_pc_o, 64'h8000_0100);
    check("dmiss_btbwe", 64'(btb_fixwe_o), 64'd1);
    check("dmiss_bhr", 64'(bpu_fixbhr_o), 64'hB5);
    check("dmiss_count", 64'(count_o), 64'd0);

    // Target miss
    set_enq(64'h500, 8'h00, 2'd2, 1'b1, 64'h200); tick(); set_idle();
    set_res(1'b0, 1'b1, 64'h300, 3'd3); tick(); set_idle();
    check("tmiss_prmiss", 64'(prmiss_o), 64'd1);
    check("tmiss_btbwe", 64'(btb_fixwe_o), 64'd1);
    check("tmiss_jaddr", bpu_fixjumpaddr_o, 64'h300);
    check("tmiss_redirect", redirect_pc_o, 64'h300);
    // Predicted taken, actually not taken
    set_enq(64'h1000, 8'h00, 2'd2, 1'b1, 64'h2000); tick(); set_idle();
    set_res(1'b1, 1'b0, 64'h0, 3'd0); tick(); set_idle();
    check("nt_prmiss", 64'(prmiss_o), 64'd1);
    check("nt_redirect", redirect_pc_o, 64'h1004);
    check("nt_btbwe", 64'(btb_fixwe_o), 64'd0);

    // Flush together with enqueue and resolve
    set_enq(64'h700, 8'h00, 2'd1, 1'b0, 64'h0); tick(); set_idle();
    set_enq(64'h800, 8'h00, 2'd1, 1'b0, 64'h0);
    set_res(1'b1, 1'b0, 64'h0, 3'd0);
    flush = 1'b1;
    tick(); set_idle();
    check("flush_fixwe", 64'(bpu_fixwe_o), 64'd1);
    check("flush_fixpc", bpu_fixpc_o, 64'h700);
    check("flush_count", 64'(count_o), 64'd0);

    // Random traffic, mostly correct predictions, occasional flush/reset
    for (int c = 0; c < 3000; c++) begin
      enq_valid_i = ($urandom_range(0, 99) < 60);
      enq_pc_i = {$urandom, $urandom} & ~64'h3;
      enq_bhr_i = 8'($urandom);
      enq_pht_i = 2'($urandom);
      enq_taken_i = 1'($urandom);
      enq_target_i = {$urandom, $urandom} & ~64'h3;
      res_valid_i = ($urandom_range(0, 99) < 50);
      res_isbr_i = 1'($urandom);
      res_jumpop_i = 3'($urandom);
      res_taken_i = 1'($urandom);
      res_target_i = {$urandom, $urandom} & ~64'h3;
      if (q.size() > 0) begin
        if ($urandom_range(0, 99) < 75) res_taken_i = q[0].taken;
        if ($urandom_range(0, 99) < 80) res_target_i = q[0].target;
      end
      flush = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 199) < 1);
      tick();
    end
    rst = 1'b0;
    set_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
